// File: rtl/rename_free_list_ctrl.sv
// Free-list and architectural-map controller for D-register renaming; replays the committed map
// into the translation table after reset and flush. Optional same-cycle reclaim bypass: FRL_RECLAIM_BYPASS_EN.
module rename_free_list_ctrl #(
  parameter  int NUM_D_REG = 32,
  parameter  int NUM_V_REG = 16,
  localparam int PW        = $clog2(NUM_D_REG)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          alloc_req,
  output logic          alloc_ready,
  output logic [PW-1:0] alloc_preg,
  input  logic          commit_valid,
  input  logic [3:0]    commit_v_reg,
  input  logic [PW-1:0] commit_p_reg,
  input  logic [PW-1:0] commit_old_preg,
  input  logic          flush,
  output logic          tt_wr_en,
  output logic [3:0]    tt_wr_v,
  output logic [PW-1:0] tt_wr_p,
  output logic          busy,
  output logic [PW:0]   free_count,
  output logic [1:0]    dbg_state_o
);

  localparam int          NUM_FREE  = NUM_D_REG - NUM_V_REG;
  localparam logic [PW:0] FREE_INIT = (PW+1)'(NUM_FREE);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW:0]   spec_head_q, spec_head_d;
  logic [PW:0]   commit_head_q, commit_head_d;
  logic [PW:0]   tail_q, tail_d;
  logic [PW-1:0] fl_q [NUM_D_REG];
  logic [PW-1:0] arch_map_q [NUM_V_REG];

  logic in_run;
  logic pool_empty;
  logic commit_fire;
  logic alloc_fire;
  logic bypass;

  assign dbg_state_o = state_q;
  assign in_run      = (state_q == ST_RUN);
  assign free_count  = tail_q - spec_head_q;
  assign pool_empty  = (free_count == '0);
  assign commit_fire = in_run & commit_valid;

`ifdef FRL_RECLAIM_BYPASS_EN
  // Empty pool: hand the preg being reclaimed this cycle straight to rename.
  assign bypass = in_run & pool_empty & commit_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Handshake: a preg is granted exactly when alloc_req & alloc_ready are both high in a
  // cycle; alloc_preg is valid whenever alloc_ready is high and does not depend on alloc_req.
  assign alloc_ready = in_run & ~flush & (~pool_empty | bypass);
  assign alloc_preg  = bypass ? commit_old_preg : fl_q[spec_head_q[PW-1:0]];
  assign alloc_fire  = alloc_req & alloc_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    spec_head_d   = spec_head_q + (PW+1)'(alloc_fire);
    commit_head_d = commit_head_q + (PW+1)'(commit_fire);
    tail_d        = tail_q + (PW+1)'(commit_fire);
    tt_wr_en      = 1'b0;
    tt_wr_v       = cnt_q;
    tt_wr_p       = '0;
    busy          = 1'b1;
    case (state_q)
      ST_INIT: begin
        tt_wr_en = n_rst;
        tt_wr_p  = PW'(cnt_q);
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b0;
        if (flush) begin
          // A commit arriving with the flush is retired, so the restart point includes it.
          spec_head_d = commit_head_q + (PW+1)'(commit_fire);
          cnt_d       = 4'd0;
          state_d     = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        tt_wr_en = 1'b1;
        tt_wr_p  = arch_map_q[cnt_q];
        if (flush) begin
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= ST_INIT;
      cnt_q         <= 4'd0;
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= FREE_INIT;
      for (int i = 0; i < NUM_D_REG; i++) begin
        fl_q[i] <= (i < NUM_FREE) ? PW'(i + NUM_V_REG) : '0;
      end
      for (int i = 0; i < NUM_V_REG; i++) begin
        arch_map_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      if (state_q == ST_INIT) begin
        arch_map_q[cnt_q] <= PW'(cnt_q);
      end
      if (commit_fire) begin
        arch_map_q[commit_v_reg]  <= commit_p_reg;
        fl_q[tail_q[PW-1:0]]      <= commit_old_preg;
      end
    end
  end

  a_free_bound: assert property (@(posedge clk) disable iff (!n_rst)
    free_count <= FREE_INIT);

  a_pool_conserved: assert property (@(posedge clk) disable iff (!n_rst)
    (tail_q - commit_head_q) == FREE_INIT);

  a_no_alloc_empty: assert property (@(posedge clk) disable iff (!n_rst)
    !(alloc_fire && pool_empty && !bypass));

  a_no_commit_recover: assert property (@(posedge clk) disable iff (!n_rst)
    !(state_q == ST_RECOVER && commit_valid));

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Directed bench for rename_free_list_ctrl: grant and translation-table-write scoreboards,
// reset/init replay, pool exhaustion, reclaim (both FRL_RECLAIM_BYPASS_EN builds), flush recovery.
module tb_rename_free_list_ctrl;

  localparam int NUM_D_REG = 32;
  localparam int PW        = 5;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          alloc_req;
  logic          alloc_ready;
  logic [PW-1:0] alloc_preg;
  logic          commit_valid;
  logic [3:0]    commit_v_reg;
  logic [PW-1:0] commit_p_reg;
  logic [PW-1:0] commit_old_preg;
  logic          flush;
  logic          tt_wr_en;
  logic [3:0]    tt_wr_v;
  logic [PW-1:0] tt_wr_p;
  logic          busy;
  logic [PW:0]   free_count;
  logic [1:0]    dbg_state;

  rename_free_list_ctrl #(.NUM_D_REG(NUM_D_REG)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_preg      (alloc_preg),
    .commit_valid    (commit_valid),
    .commit_v_reg    (commit_v_reg),
    .commit_p_reg    (commit_p_reg),
    .commit_old_preg (commit_old_preg),
    .flush           (flush),
    .tt_wr_en        (tt_wr_en),
    .tt_wr_v         (tt_wr_v),
    .tt_wr_p         (tt_wr_p),
    .busy            (busy),
    .free_count      (free_count),
    .dbg_state_o     (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [PW-1:0]   exp_q[$];
  logic [4+PW-1:0] tt_exp_q[$];
  logic [PW-1:0]   arch_model [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Sample point mid-cycle; pop scoreboards for whatever the DUT produces this cycle.
  task automatic settle();
    logic [PW-1:0]   e;
    logic [4+PW-1:0] t;
    #4;
    if (tt_wr_en === 1'b1) begin
      if (tt_exp_q.size() == 0) check("tt_unexpected_wr", 32'(tt_wr_en), 32'd0);
      else begin
        t = tt_exp_q.pop_front();
        check("tt_wr", 32'({tt_wr_v, tt_wr_p}), 32'(t));
      end
    end
    if (alloc_req === 1'b1 && alloc_ready === 1'b1) begin
      if (exp_q.size() == 0) check("alloc_unexpected", 32'(alloc_ready), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("alloc_preg", 32'(alloc_preg), 32'(e));
      end
    end
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_inputs();
    alloc_req       = 1'b0;
    commit_valid    = 1'b0;
    commit_v_reg    = '0;
    commit_p_reg    = '0;
    commit_old_preg = '0;
    flush           = 1'b0;
  endtask

  task automatic push_replay(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) tt_exp_q.push_back({4'(v), arch_model[v]});
  endtask

  task automatic run_busy(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      settle();
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_no_ready"}, 32'(alloc_ready), 32'd0);
      advance();
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    clear_inputs();
    advance();
    settle();
    check("rst_tt_wr_en", 32'(tt_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd0);
    advance();
    n_rst = 1'b1;
    for (int v = 0; v < 16; v++) arch_model[v] = PW'(v);
    push_replay(0, 15);
    run_busy(16, "init");
    check("init_drained", 32'(tt_exp_q.size()), 32'd0);
  endtask

  task automatic commit(input int v, input int p, input int old);
    commit_valid    = 1'b1;
    commit_v_reg    = 4'(v);
    commit_p_reg    = PW'(p);
    commit_old_preg = PW'(old);
    arch_model[v]   = PW'(p);
  endtask

  initial begin
    n_rst = 1'b0;
    clear_inputs();

    // Reset and identity init
    do_reset();
    settle();
    check("run_busy", 32'(busy), 32'd0);
    check("run_free_count", 32'(free_count), 32'd16);
    check("run_alloc_preg", 32'(alloc_preg), 32'd16);
    check("run_alloc_ready", 32'(alloc_ready), 32'd1);
    advance();

    // Drain the pool
    alloc_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(PW'(16 + i));
      settle();
      check("drain_free_count", 32'(free_count), 32'(16 - i));
      advance();
    end
    settle();
    check("empty_ready", 32'(alloc_ready), 32'd0);
    check("empty_free_count", 32'(free_count), 32'd0);
    advance();

    // Reclaim into an empty pool
    commit(3, 16, 3);
`ifdef FRL_RECLAIM_BYPASS_EN
    exp_q.push_back(PW'(3));
    settle();
    check("bypass_ready", 32'(alloc_ready), 32'd1);
    advance();
    commit_valid = 1'b0;
    settle();
    check("bypass_after_ready", 32'(alloc_ready), 32'd0);
    check("bypass_after_free", 32'(free_count), 32'd0);
    advance();
`else
    settle();
    check("nobypass_ready", 32'(alloc_ready), 32'd0);
    advance();
    commit_valid = 1'b0;
    exp_q.push_back(PW'(3));
    settle();
    check("reclaim_ready", 32'(alloc_ready), 32'd1);
    check("reclaim_free", 32'(free_count), 32'd1);
    advance();
    settle();
    check("reclaim_after_ready", 32'(alloc_ready), 32'd0);
    advance();
`endif
    alloc_req = 1'b0;
    check("grants_drained_a", 32'(exp_q.size()), 32'd0);

    // Allocate 4, commit 2, flush, replay
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(PW'(16 + i));
      step();
    end
    alloc_req = 1'b0;
    commit(1, 16, 1);
    step();
    commit(2, 17, 2);
    step();
    commit_valid = 1'b0;
    flush        = 1'b1;
    alloc_req    = 1'b1;
    settle();
    check("flush_blocks_alloc", 32'(alloc_ready), 32'd0);
    advance();
    flush     = 1'b0;
    alloc_req = 1'b0;
    push_replay(0, 15);
    run_busy(16, "recover1");
    check("recover1_drained", 32'(tt_exp_q.size()), 32'd0);
    alloc_req = 1'b1;
    exp_q.push_back(PW'(18));
    settle();
    check("recover1_busy_clear", 32'(busy), 32'd0);
    check("recover1_free", 32'(free_count), 32'd16);
    advance();
    exp_q.push_back(PW'(19));
    step();
    exp_q.push_back(PW'(20));
    step();
    alloc_req = 1'b0;

    // Flush with a simultaneous commit
    commit(5, 18, 5);
    flush = 1'b1;
    settle();
    check("flush_commit_ready", 32'(alloc_ready), 32'd0);
    advance();
    clear_inputs();
    push_replay(0, 15);
    run_busy(16, "recover2");
    check("recover2_drained", 32'(tt_exp_q.size()), 32'd0);
    settle();
    check("recover2_free", 32'(free_count), 32'd16);
    check("recover2_alloc_preg", 32'(alloc_preg), 32'd19);
    advance();

    // Flush again in the middle of recovery
    flush = 1'b1;
    step();
    flush = 1'b0;
    push_replay(0, 8);
    run_busy(8, "recover3a");
    flush = 1'b1;
    settle();
    check("recover3_flush_busy", 32'(busy), 32'd1);
    advance();
    flush = 1'b0;
    check("recover3a_drained", 32'(tt_exp_q.size()), 32'd0);
    push_replay(0, 15);
    run_busy(16, "recover3b");
    check("recover3b_drained", 32'(tt_exp_q.size()), 32'd0);
    settle();
    check("recover3_busy_clear", 32'(busy), 32'd0);
    check("recover3_free", 32'(free_count), 32'd16);
    check("recover3_alloc_preg", 32'(alloc_preg), 32'd19);
    advance();
    alloc_req = 1'b1;
    exp_q.push_back(PW'(19));
    step();
    alloc_req = 1'b0;
    step();

    // final report
    check("grants_drained_b", 32'(exp_q.size()), 32'd0);
    check("tt_drained_final", 32'(tt_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
